// File: rtl/fifo_arb_pkg.sv
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            found,
  output logic [IW-1:0]   idx
);

  // Scan upward from last+1, wrapping modulo NREQ; the first hit wins.
  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned BURST = DEF_BURST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       data,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     fifo_wr,
  output logic [DW-1:0]            fifo_din,
  input  logic                     fifo_full
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(BURST + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          busy_q, busy_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          req_own;
  logic [DW-1:0] din_own;
  logic          xfer;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    req_own  = 1'b0;
    din_own  = '0;
    ack      = '0;
    xfer     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        req_own = req[i];
        din_own = data[i*DW +: DW];
      end
    end
    // fifo_full is deliberately combinational here so a falling full resumes in-cycle.
    xfer = (state_q == GRANT) && req_own && !fifo_full;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        ack[i] = xfer;
      end
    end
    fifo_wr  = xfer;
    fifo_din = (state_q == GRANT) ? din_own : '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          beats_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beats_d = beats_q + 1'b1;
        end
        if (!req_own || (xfer && (beats_q == BW'(BURST - 1)))) begin
          state_d = IDLE;
          last_d  = owner_q;
          beats_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      beats_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign grant_id = owner_q;

endmodule
